digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; SHALL be at least 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 ena  input  1  global enable; low freezes all state.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored).
REQ-011 cin  input  1  carry-in for add.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 carry_out  output  1  unsigned carry out of MSB (for sub: 1 = no borrow, A>=B).
REQ-016 overflow  output  1  signed two's-complement overflow.

Function
REQ-017 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE, out_valid SHALL be 1 only in DONE.
REQ-018 IDLE, in_valid=1, ena=1: capture a, b XOR {WIDTH{sub}}, and initial carry = sub ? 1 : cin; clear digit counter; go BUSY.
REQ-019 BUSY: each enabled cycle add one DIGIT-bit slice, LSB slice first, with running carry; write slice into result register; increment counter.
REQ-020 After N = WIDTH/DIGIT BUSY cycles go DONE; out_valid SHALL rise N cycles after the accept edge (N=4 at defaults).
REQ-021 overflow SHALL equal carry into MSB XOR carry out of MSB, evaluated on the final slice.
REQ-022 DONE: sum, carry_out, overflow SHALL hold stable until out_valid and out_ready are both 1 on an enabled edge, then go IDLE.
REQ-023 in_valid SHALL be ignored outside IDLE; no operand SHALL be accepted in the handshake-completion cycle of DONE.
REQ-024 Result wraps modulo 2^WIDTH (see REQ-030 for override).
REQ-025 ena=0: state, counter, carry and outputs SHALL hold; handshakes SHALL not complete.
REQ-026 sum/carry_out/overflow SHALL be 0 in IDLE and BUSY; valid only while out_valid=1.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, counter=0, regardless of clk or ena.
REQ-028 Reset in BUSY or DONE SHALL discard the operation; no result SHALL appear after release.
REQ-029 First accept after reset release SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-030 Macro ADDER_SAT_EN: when defined, on overflow=1 sum SHALL saturate to signed max (0111...1) if A's MSB is 0, else signed min (1000...0); overflow and carry_out unchanged.
REQ-031 Without ADDER_SAT_EN, sum SHALL wrap per REQ-024 and no saturation logic SHALL be present.

Verification (WIDTH=16, DIGIT=4)
REQ-032 a=0x7FFF, b=0x0001, sub=0, cin=0 -> out_valid 4 cycles after accept, sum=0x8000, carry_out=0, overflow=1 (sum=0x7FFF with ADDER_SAT_EN).
REQ-033 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry_out=1, overflow=0; a=0x1234, b=0x1111, cin=1 -> sum=0x2346.
REQ-034 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry_out=0, overflow=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1 (0x8000 with ADDER_SAT_EN).
REQ-035 out_ready held 0 for 10 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-036 ena=0 for 3 cycles mid-BUSY -> out_valid delayed exactly 3 cycles, result unchanged.
REQ-037 rst_n pulsed low mid-BUSY -> outputs zero immediately, in_ready=1, no out_valid afterwards.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first.
// Optional macro ADDER_SAT_EN saturates the result to signed max/min on overflow.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a transfer happens on an enabled rising edge where valid and ready are both 1.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, res;
  logic             cout_reg, ovf_reg;
  logic             last;

  logic [DIGIT-1:0] a_s, b_s, s_s;
  logic [DIGIT:0]   s_ext;
  logic             c_msb, s_cout, s_ovf;
  logic [WIDTH-1:0] res_shift, res_final;

  assign last = (cnt == CW'(N - 1));

  // Operands shift right each cycle, so the active slice always sits in the low digit.
  always_comb begin
    a_s       = a_reg[DIGIT-1:0];
    b_s       = b_reg[DIGIT-1:0];
    s_ext     = {1'b0, a_s} + {1'b0, b_s} + {{DIGIT{1'b0}}, carry};
    s_s       = s_ext[DIGIT-1:0];
    s_cout    = s_ext[DIGIT];
    c_msb     = a_s[DIGIT-1] ^ b_s[DIGIT-1] ^ s_s[DIGIT-1];
    s_ovf     = c_msb ^ s_cout;
    res_shift = res >> DIGIT;
    res_shift[WIDTH-1 -: DIGIT] = s_s;
    res_final = res_shift;
`ifdef ADDER_SAT_EN
    // On the final slice a_s[DIGIT-1] is still A's sign bit.
    if (s_ovf) res_final = a_s[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    sum       = out_valid ? res : '0;
    carry_out = out_valid & cout_reg;
    overflow  = out_valid & ovf_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      res      <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg    <= a;
          b_reg    <= b ^ {WIDTH{sub}};
          carry    <= sub ? 1'b1 : cin;
          cnt      <= '0;
          res      <= '0;
          cout_reg <= 1'b0;
          ovf_reg  <= 1'b0;
        end
        BUSY: begin
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= s_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            res      <= res_final;
            cout_reg <= s_cout;
            ovf_reg  <= s_ovf;
          end else begin
            res <= res_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed corner cases plus random operations,
// compared against an arithmetic reference model through an expected queue.
module tb_digit_serial_adder;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, carry_out, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s, input logic c);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (s) begin
      full = {1'b0, x} + {1'b0, ~y} + 17'd1;
      r    = full[W-1:0];
      v    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {16'd0, c};
      r    = full[W-1:0];
      v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
`ifdef ADDER_SAT_EN
    if (v) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {v, full[W], r};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input logic tc, input int stall, input int hold);
    int lat;
    logic [W+1:0] e;
    logic [W-1:0] held;
    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b0; ena = 1'b1;
    check("ready_idle", in_ready, 1);
    exp_q.push_back(model(ta, tb, ts, tc));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0;
    check("busy_zero", {in_ready, out_valid, carry_out, overflow, sum}, 0);
    while (!out_valid && lat < 50) begin
      ena = !(stall > 0 && lat >= 1 && lat < 1 + stall);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    check("latency", lat, N + stall);
    e = exp_q.pop_front();
    check("sum", sum, {16'd0, e[W-1:0]});
    check("carry_out", carry_out, e[W]);
    check("overflow", overflow, e[W+1]);
    held = sum;
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_state", {in_ready, out_valid}, 2'b01);
      check("hold_sum", sum, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release", {in_ready, out_valid}, 2'b10);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #1;
    check("reset_out", {in_ready, out_valid, carry_out, overflow, sum}, 32'h0002_0000 >> 0 & 0 | {1'b1, 19'd0});
    #13;
    rst_n = 1'b1;

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b1, 0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 0);
    run_op(16'h4321, 16'h0F0F, 1'b0, 1'b0, 0, 10);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 3, 0);

    // Reset mid-operation must discard the transaction.
    @(negedge clk);
    a = 16'h7FFF; b = 16'h7FFF; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {in_ready, out_valid, carry_out, overflow, sum}, {1'b1, 19'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) check("ghost_valid", out_valid, 0);
    end
    check("post_rst_idle", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (i % 4 == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 3));

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
